// File: rtl/multi_debouncer_pkg.sv
// Shared defaults and types for the multi-channel push-button conditioner.
// Cycle counts are derived from the board clock.
package multi_debouncer_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int HOLD_500MS    = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

  typedef struct packed {
    logic state;
    logic press_pulse;
    logic release_pulse;
    logic hold;
    logic repeat_pulse;
  } ch_out_t;

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Pin-side and control-side bundle of the button conditioner.
interface multi_debouncer_if #(parameter int N_CH = 3);
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] state;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] hold;
  logic [N_CH-1:0] repeat_pulse;

  modport master (output btn, input state, press_pulse, release_pulse, hold, repeat_pulse);
  modport slave  (input btn, output state, press_pulse, release_pulse, hold, repeat_pulse);
endinterface

// File: rtl/multi_debouncer_channel.sv
// One button channel: 2-flop sync, symmetric debounce, edge pulses, hold and auto-repeat.
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_btn,
  output ch_out_t o_out
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int HD_W = cnt_w(HOLD_CYCLES);
  localparam int RP_W = cnt_w(REPEAT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(HOLD_CYCLES);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_db_cnt;
  logic [HD_W-1:0] r_hold_cnt;
  logic [RP_W-1:0] r_rep_cnt;
  logic            r_state, r_press, r_rel, r_hold, r_rep;

  logic            w_flip, w_state_nxt, w_hold_nxt, w_rep_nxt;
  logic [DB_W-1:0] w_db_nxt;
  logic [HD_W-1:0] w_hold_cnt_nxt;
  logic [RP_W-1:0] w_rep_cnt_nxt;

  // The sample that completes DEBOUNCE_CYCLES disagreeing samples flips the state.
  assign w_flip      = (r_sync[1] != r_state) && (r_db_cnt == DB_LAST);
  assign w_state_nxt = r_state ^ w_flip;
  assign w_db_nxt    = ((r_sync[1] == r_state) || w_flip) ? '0 : r_db_cnt + 1'b1;

  // Hold count is evaluated on the next state so the press cycle already counts as 1.
  assign w_hold_cnt_nxt = !w_state_nxt             ? '0 :
                          (r_hold_cnt == HD_MAX)   ? r_hold_cnt : r_hold_cnt + 1'b1;
  assign w_hold_nxt     = (w_hold_cnt_nxt == HD_MAX);

  assign w_rep_cnt_nxt = (!w_hold_nxt || !r_hold || (r_rep_cnt == RP_LAST)) ? '0
                                                                            : r_rep_cnt + 1'b1;
  assign w_rep_nxt     = w_hold_nxt && (!r_hold || ((REPEAT_CYCLES > 0) && (w_rep_cnt_nxt == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_state    <= 1'b0;
      r_press    <= 1'b0;
      r_rel      <= 1'b0;
      r_hold     <= 1'b0;
      r_rep      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_btn};
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_state    <= w_state_nxt;
      r_press    <= w_flip && !r_state;
      r_rel      <= w_flip && r_state;
      r_hold     <= w_hold_nxt;
      r_rep      <= w_rep_nxt;
    end
  end

  assign o_out = '{state: r_state, press_pulse: r_press, release_pulse: r_rel,
                   hold: r_hold, repeat_pulse: r_rep};

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button conditioner for the stopwatch front panel; channels are independent.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_debouncer_if.slave   bus
);

  ch_out_t         w_out [N_CH];
  logic [N_CH-1:0] w_state, w_press, w_rel, w_hold, w_rep;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_btn (bus.btn[g]),
      .o_out (w_out[g])
    );
  end

  always_comb begin
    w_state = '0;
    w_press = '0;
    w_rel   = '0;
    w_hold  = '0;
    w_rep   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_state[i] = w_out[i].state;
      w_press[i] = w_out[i].press_pulse;
      w_rel[i]   = w_out[i].release_pulse;
      w_hold[i]  = w_out[i].hold;
      w_rep[i]   = w_out[i].repeat_pulse;
    end
  end

  assign bus.state         = w_state;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_rel;
  assign bus.hold          = w_hold;
  assign bus.repeat_pulse  = w_rep;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: window-based reference model checked every cycle, plus directed pins.
module tb_multi_debouncer;

  localparam int NC = 2;
  localparam int DB = 4;
  localparam int HD = 10;
  localparam int RP = 3;
  localparam int HMAX = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  multi_debouncer_if #(.N_CH(NC)) bus_if ();

  multi_debouncer #(
    .N_CH(NC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HD), .REPEAT_CYCLES(RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: pin history indexed by edge number since reset.
  logic [NC-1:0] e_state = '0, e_press = '0, e_rel = '0, e_hold = '0, e_rep = '0;
  bit   pin_h [NC][HMAX];
  int   press_k [NC];
  int   k = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0;
        e_state = '0; e_press = '0; e_rel = '0; e_hold = '0; e_rep = '0;
      end else if (k < HMAX - 1) begin
        k++;
        for (int c = 0; c < NC; c++) begin
          bit all_diff;
          int held;
          pin_h[c][k] = bus_if.btn[c];
          // The debouncer sees the pin two edges late; flip when the last DB seen samples disagree.
          all_diff = (k >= DB);
          for (int j = k - DB + 1; j <= k; j++) begin
            if (j >= 1) begin
              if (((j >= 3) ? pin_h[c][j-2] : 1'b0) == e_state[c]) all_diff = 1'b0;
            end
          end
          e_press[c] = 1'b0;
          e_rel[c]   = 1'b0;
          if (all_diff) begin
            e_state[c] = ~e_state[c];
            if (e_state[c]) begin
              e_press[c] = 1'b1;
              press_k[c] = k;
            end else begin
              e_rel[c] = 1'b1;
            end
          end
          if (e_state[c]) begin
            held      = k - press_k[c] + 1;
            e_hold[c] = (held >= HD);
            e_rep[c]  = (held >= HD) && (((held - HD) % RP) == 0);
          end else begin
            e_hold[c] = 1'b0;
            e_rep[c]  = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("m_state",   32'(bus_if.state),         32'(e_state));
      chk("m_press",   32'(bus_if.press_pulse),   32'(e_press));
      chk("m_release", 32'(bus_if.release_pulse), 32'(e_rel));
      chk("m_hold",    32'(bus_if.hold),          32'(e_hold));
      chk("m_repeat",  32'(bus_if.repeat_pulse),  32'(e_rep));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_state"},   32'(bus_if.state),         0);
    chk({nm, "_press"},   32'(bus_if.press_pulse),   0);
    chk({nm, "_release"}, 32'(bus_if.release_pulse), 0);
    chk({nm, "_hold"},    32'(bus_if.hold),          0);
    chk({nm, "_repeat"},  32'(bus_if.repeat_pulse),  0);
  endtask

  initial begin
    bus_if.btn = '0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Clean press: visible exactly 6 clocks after the pin rises, one cycle wide.
    bus_if.btn[0] = 1'b1;
    cyc(5);
    chk("press_early_state", 32'(bus_if.state), 0);
    cyc(1);
    chk("press_state", 32'(bus_if.state), 1);
    chk("press_pulse", 32'(bus_if.press_pulse), 1);
    cyc(1);
    chk("press_width", 32'(bus_if.press_pulse), 0);

    // Hold after 9 more clocks, then repeat every 3.
    cyc(7);
    chk("hold_early", 32'(bus_if.hold), 0);
    cyc(1);
    chk("hold_on", 32'(bus_if.hold), 1);
    chk("rep_first", 32'(bus_if.repeat_pulse), 1);
    cyc(1);
    chk("rep_gap", 32'(bus_if.repeat_pulse), 0);
    cyc(2);
    chk("rep_second", 32'(bus_if.repeat_pulse), 1);

    // Short release glitch is rejected; a real release is debounced.
    bus_if.btn[0] = 1'b0;
    cyc(3);
    bus_if.btn[0] = 1'b1;
    cyc(8);
    chk("glitch_state", 32'(bus_if.state), 1);
    bus_if.btn[0] = 1'b0;
    cyc(5);
    chk("rel_early_state", 32'(bus_if.state), 1);
    cyc(1);
    chk("rel_state", 32'(bus_if.state), 0);
    chk("rel_pulse", 32'(bus_if.release_pulse), 1);
    chk("rel_hold", 32'(bus_if.hold), 0);
    chk("rel_repeat", 32'(bus_if.repeat_pulse), 0);
    cyc(1);
    chk("rel_width", 32'(bus_if.release_pulse), 0);

    // Bouncing press: pulse only 6 clocks after the final rise.
    cyc(2);
    bus_if.btn[0] = 1'b1; cyc(2);
    bus_if.btn[0] = 1'b0; cyc(2);
    bus_if.btn[0] = 1'b1; cyc(2);
    bus_if.btn[0] = 1'b0; cyc(2);
    bus_if.btn[0] = 1'b1;
    cyc(5);
    chk("bounce_early", 32'(bus_if.press_pulse), 0);
    cyc(1);
    chk("bounce_press", 32'(bus_if.press_pulse), 1);

    // Independence: simultaneous press, then ch1 chatter leaves both channels holding.
    bus_if.btn = '0;
    cyc(8);
    chk("indep_idle", 32'(bus_if.state), 0);
    bus_if.btn = 2'b11;
    cyc(6);
    chk("indep_press", 32'(bus_if.press_pulse), 3);
    for (int i = 0; i < 8; i++) begin
      bus_if.btn[1] = ~bus_if.btn[1];
      cyc(1);
    end
    cyc(1);
    chk("indep_hold", 32'(bus_if.hold), 3);
    chk("indep_repeat", 32'(bus_if.repeat_pulse), 3);

    // Async reset mid-hold, then re-qualify with the button still down.
    bus_if.btn = 2'b01;
    cyc(2);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("rst_requal_early", 32'(bus_if.state), 0);
    cyc(1);
    chk("rst_requal_state", 32'(bus_if.state), 1);
    chk("rst_requal_press", 32'(bus_if.press_pulse), 1);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
